load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/core_pkg.sv | 58 +++++
 rtl/load_align.sv | 26 ++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and small access-decoding helpers used by both the top and the aligner.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } lsu_state_e;

  // Unsupported encodings are folded into the misaligned/error path.
  function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = !is_store;
      F3_HU:   ok = !is_store && !addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (funct3)
      F3_B:    strb = 4'b0001 << addr_lo;
      F3_H:    strb = 4'b0011 << addr_lo;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicating across lanes lets the strobes alone pick the target bytes.
  function automatic logic [31:0] store_data(input logic [2:0] funct3,
                                             input logic [31:0] wdata);
    logic [31:0] data;
    case (funct3)
      F3_B:    data = {4{wdata[7:0]}};
      F3_H:    data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-lane selection and sign/zero extension of a memory word.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store unit: address generation, alignment
// checks, store lane steering, load extension and a load-response timeout.
module load_store_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [31:0]      addr_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic             is_store_q;
  logic [31:0]      wdata_q;
  logic [31:0]      load_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] addr_sum;
  logic        accept;
  logic        timeout;
  logic [31:0] load_ext;

  assign addr_sum = req_base + req_offset;
  assign accept   = req_valid && req_ready;
  assign timeout  = (cnt_q == CNT_LAST);

  load_align u_align (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (load_ext)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = 4'b0000;
    wb_en     = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_d = access_ok(req_is_store, req_funct3, addr_sum[1:0]) ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_wstrb = is_store_q ? store_strobe(funct3_q, addr_q[1:0]) : 4'b0000;
        if (mem_gnt) state_d = is_store_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving on the last allowed cycle still completes the load.
        if (mem_rvalid)   state_d = ST_WB;
        else if (timeout) state_d = ST_ERR;
      end
      ST_WB: begin
        wb_en   = (rd_q != 5'd0);
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are cleared by reset so no stale address,
  // data or register index is visible on the ports after rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      is_store_q <= 1'b0;
      wdata_q    <= '0;
      load_q     <= '0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        addr_q     <= addr_sum;
        funct3_q   <= req_funct3;
        rd_q       <= req_rd;
        is_store_q <= req_is_store;
        wdata_q    <= req_wdata;
      end
      if (state_q == ST_WAIT && mem_rvalid) load_q <= load_ext;
      if (state_q == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      else                    cnt_q <= '0;
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = store_data(funct3_q, wdata_q);
  assign wb_rd     = rd_q;
  assign wb_data   = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario-driven bench for load_store_unit; writebacks are checked against a
// queue of expected {rd, data} pushed when each load response is driven.
module tb_load_store_unit;

  localparam int TO = 16;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] req_base = '0, req_offset = '0, req_wdata = '0;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;
  logic        wb_en, busy, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int  n_cmp = 0;
  int  n_bad = 0;
  wb_t sb_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_rd(req_rd), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err(err)
  );

  // Writeback monitor: every wb_en must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_en) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
      end else begin
        wb_t exp_wb;
        exp_wb = sb_q.pop_front();
        if (wb_rd !== exp_wb.rd || wb_data !== exp_wb.data) begin
          n_bad++;
          $display("FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                   wb_rd, wb_data, exp_wb.rd, exp_wb.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [7:0]  by;
    logic [15:0] hw;
    case (lo)
      2'd0: by = w[7:0];
      2'd1: by = w[15:8];
      2'd2: by = w[23:16];
      default: by = w[31:24];
    endcase
    hw = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      LB:  return by[7] ? {24'hFFFFFF, by} : {24'h0, by};
      LBU: return {24'h0, by};
      LH:  return hw[15] ? {16'hFFFF, hw} : {16'h0, hw};
      LHU: return {16'h0, hw};
      default: return w;
    endcase
  endfunction

  task automatic issue(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_idle: got req_ready=%b, expected 1", req_ready);
    end
    req_is_store = st; req_funct3 = f3; req_rd = rd;
    req_base = base; req_offset = off; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_base = $urandom; req_offset = $urandom; req_wdata = $urandom;
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] rdata, input int gnt_delay,
                          input int rv_delay, input logic [31:0] exp_data);
    logic [31:0] ea;
    ea = base + off;
    ea[1:0] = 2'b00;
    issue(1'b0, f3, rd, base, off, 32'h0);
    for (int i = 0; i <= gnt_delay; i++) begin
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL load_req[%0d]: got req=%b we=%b addr=%h ready=%b, expected 1 0 %h 0",
                 i, mem_req, mem_we, mem_addr, req_ready, ea);
      end
      if (i < gnt_delay) begin
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (rv_delay) @(negedge clk);
    if (rd != 5'd0) sb_q.push_back('{rd: rd, data: exp_data});
    mem_rdata = rdata; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    n_cmp++;
    if (wb_en !== (rd != 5'd0) || err !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_latency: got wb_en=%b err=%b, expected wb_en=%b err=0", wb_en, err, rd != 5'd0);
    end
    @(negedge clk);
    n_cmp++;
    if (wb_en !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL load_done: got wb_en=%b ready=%b busy=%b, expected 0 1 0", wb_en, req_ready, busy);
    end
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] wd, input int gnt_delay, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    issue(1'b1, f3, 5'd7, base, off, wd);
    for (int i = 0; i <= gnt_delay; i++) begin
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr ||
          mem_wstrb !== exp_strb || mem_wdata !== exp_wdata) begin
        n_bad++;
        $display("FAIL store_req[%0d]: got req=%b we=%b addr=%h strb=%b wdata=%h, expected 1 1 %h %b %h",
                 i, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, exp_addr, exp_strb, exp_wdata);
      end
      if (i < gnt_delay) @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || wb_en !== 1'b0) begin
      n_bad++;
      $display("FAIL store_done: got ready=%b req=%b wb_en=%b, expected 1 0 0", req_ready, mem_req, wb_en);
    end
  endtask

  task automatic run_misaligned(input logic st, input logic [2:0] f3, input logic [31:0] base,
                                input logic [31:0] off);
    issue(st, f3, 5'd3, base, off, 32'h1234_5678);
    n_cmp++;
    if (err !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_err: f3=%b got err=%b req=%b, expected 1 0", f3, err, mem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL misalign_ret: f3=%b got err=%b req=%b ready=%b, expected 0 0 1",
               f3, err, mem_req, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || wb_en !== 1'b0 || err !== 1'b0 ||
        mem_wstrb !== 4'b0000 || mem_addr !== 32'h0 || wb_data !== 32'h0 || wb_rd !== 5'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b we=%b wb=%b err=%b strb=%b addr=%h wbd=%h rd=%0d, expected all 0",
               mem_req, mem_we, wb_en, err, mem_wstrb, mem_addr, wb_data, wb_rd);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b ready=%b, expected 0 1", busy, req_ready);
    end
  endtask

  task automatic test_lw();
    run_load(LW, 5'd5, 32'h1000, 32'd4, 32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF);
  endtask

  task automatic test_byte_loads();
    run_load(LB,  5'd6, 32'h2000, 32'd3, 32'h80FF_FFFF, 0, 0, 32'hFFFF_FF80);
    run_load(LBU, 5'd6, 32'h2000, 32'd3, 32'h80FF_FFFF, 1, 1, 32'h0000_0080);
    run_load(LH,  5'd9, 32'h2010, 32'hFFFF_FFF2, 32'h8001_7FFF, 0, 0, 32'hFFFF_8001);
    run_load(LHU, 5'd9, 32'h2002, 32'd0, 32'h8001_7FFF, 0, 0, 32'h0000_8001);
  endtask

  task automatic test_stores();
    run_store(LH, 32'h3000, 32'd2, 32'h0000_ABCD, 0, 32'h3000, 4'b1100, 32'hABCD_ABCD);
    run_store(LB, 32'h3000, 32'd1, 32'hFFFF_FF5A, 2, 32'h3000, 4'b0010, 32'h5A5A_5A5A);
    run_store(LW, 32'h4000, 32'd8, 32'h0102_0304, 0, 32'h4008, 4'b1111, 32'h0102_0304);
  endtask

  task automatic test_misaligned();
    run_misaligned(1'b0, LW, 32'h1000, 32'd2);
    run_misaligned(1'b0, LH, 32'h1000, 32'd3);
    run_misaligned(1'b1, LW, 32'h1001, 32'd0);
    run_misaligned(1'b0, 3'b011, 32'h1000, 32'd0);
    run_misaligned(1'b0, 3'b110, 32'h1000, 32'd0);
    run_misaligned(1'b1, LBU, 32'h1000, 32'd0);
  endtask

  task automatic test_stall();
    run_load(LW, 5'd12, 32'h5000, 32'h0000_0010, 32'hCAFE_F00D, 5, 0, 32'hCAFE_F00D);
  endtask

  task automatic test_rd_zero();
    run_load(LW, 5'd0, 32'h6000, 32'd0, 32'h1111_2222, 0, 1, 32'h0);
  endtask

  task automatic test_timeout();
    int waited;
    issue(1'b0, LW, 5'd4, 32'h7000, 32'd0, 32'h0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    waited = 0;
    while (err !== 1'b1 && waited < TO + 8) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (waited !== TO) begin
      n_bad++;
      $display("FAIL timeout_cycles: got err after %0d cycles, expected %0d", waited, TO);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_ret: got err=%b ready=%b, expected 0 1", err, req_ready);
    end
    // Response on the very last cycle before timeout must still complete.
    run_load(LW, 5'd8, 32'h7000, 32'd4, 32'h5555_AAAA, 0, TO - 1, 32'h5555_AAAA);
  endtask

  task automatic test_reset_mid();
    issue(1'b0, LW, 5'd10, 32'h8000, 32'd4, 32'h0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wstrb !== 4'b0 || mem_wdata !== 32'h0 || wb_en !== 1'b0 ||
        err !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b ready=%b req=%b addr=%h wb=%b err=%b rd=%0d, expected 0 1 0 0 0 0 0",
               busy, req_ready, mem_req, mem_addr, wb_en, err, wb_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wb_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_stray_rvalid: got busy=%b wb_en=%b, expected 0 0", busy, wb_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  fs[5];
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] base, rdata;
    fs[0] = LB; fs[1] = LH; fs[2] = LW; fs[3] = LBU; fs[4] = LHU;
    for (int i = 0; i < 10; i++) begin
      f3 = fs[$urandom_range(0, 4)];
      lo = 2'($urandom_range(0, 3));
      if (f3 == LW) lo = 2'b00;
      if (f3 == LH || f3 == LHU) lo[0] = 1'b0;
      base  = $urandom & 32'hFFFF_FFF0;
      rdata = $urandom;
      run_load(f3, 5'($urandom_range(1, 31)), base, {30'h0, lo}, rdata,
               $urandom_range(0, 2), $urandom_range(0, 3), ref_load(rdata, lo, f3));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_stores();
    test_misaligned();
    test_stall();
    test_rd_zero();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL wb_missing: got %0d writebacks outstanding, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
